uart_tx: RTL
============

# uart_tx

Serialising UART transmitter that drains the transmit-side FIFO and drives the serial line. It sits directly downstream of the TX FIFO: it pops one word at a time through the FIFO's read port and emits it as an asynchronous frame (start, LSB-first data, optional parity, 1 or 2 stop bits) at a fixed baud rate derived from the system clock.

## Interface

- `data_size`, 8: data bits per frame; must equal the FIFO `data_size`.
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: with `PARITY_EN` set, 0 gives even parity and 1 gives odd parity.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `srst`  in  1  reset, asynchronous and active-high.
- `fifo_dout`  in  `data_size`  FIFO head word, valid whenever `fifo_empty` is 0 (fall-through).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  pop strobe to FIFO `rd_en`, one cycle per frame.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is on the line.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- **Load condition:** (IDLE, or STOP with the final stop bit at terminal count) and `fifo_empty`=0.
- **Pop:** `fifo_rd_en` is combinational and equals the load condition, forced to 0 while `srst`=1.
  - On the same edge, `fifo_dout` is latched into the shift register and the state goes to START.
  - The FIFO pops on that same edge, so there is never a double pop.
- **Baud counter:** width `$clog2(CLKS_PER_BIT)`. Cleared on load and on every bit boundary. Terminal count is `CLKS_PER_BIT-1`. Every bit lasts exactly `CLKS_PER_BIT` cycles.
- **START:** `tx`=0. At terminal count go to DATA with bit index 0.
- **DATA:** `tx` = shift register LSB. At terminal count, shift right and increment the index. After bit `data_size-1`, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY:** `tx` = XOR of the latched byte, inverted when `PARITY_ODD`. Computed from the byte latched at load, not the shifted remainder.
- **STOP:** `tx`=1 for `STOP_BITS` bit periods. At the end, reload (load condition true) or go to IDLE.
- **Outputs:** `tx` and `busy` are registered. `busy`=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- **FIFO empty:** the block stays in IDLE with `tx`=1 indefinitely and never asserts `fifo_rd_en`.
- **Reset:**
  - Reset values: state IDLE, `tx`=1, `busy`=0, `fifo_rd_en`=0, counters 0, shift register 0.
  - Reset mid-frame aborts the frame immediately. The popped byte is lost and is not re-read.

## Timing

- Pop to start bit: `tx` falls on the same edge where `fifo_rd_en` is sampled high; 0 cycles of extra latency.
- Frame length is `(1 + data_size + PARITY_EN + STOP_BITS) * CLKS_PER_BIT` cycles.
- Back-to-back frames have no idle gap. Consecutive `fifo_rd_en` pulses are exactly one frame length apart while the FIFO is non-empty.
- `fifo_dout` must be stable during the cycle `fifo_rd_en` is high. The FIFO guarantees this because its read data is combinational from the read pointer.
- A write into an empty FIFO is visible one cycle later via `fifo_empty`=0. The first pop occurs in that cycle.

## Structure

- Shared package `uart_pkg`:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - default `CLKS_PER_BIT`;
  - line idle level (1).
- The receiver will reuse the same package.
- One sub-module, `uart_baud_gen`:
  - inputs `clk`, `srst`, a clear, and an enable;
  - output: a one-cycle terminal-count tick.
- The FSM, shift register, bit index, stop-bit count and parity live in `uart_tx`.

## Test plan

- **Single byte:** `CLKS_PER_BIT`=16, no parity, 1 stop; FIFO holds 0xA5.
  - One `fifo_rd_en` pulse.
  - `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each held 16 cycles.
  - `busy` high 160 cycles, then `tx`=1 and `busy`=0.
- **Back-to-back:** FIFO holds 0x00 then 0xFF.
  - Exactly 2 pops, 160 cycles apart.
  - Stop bit of frame 1 followed directly by start bit of frame 2; no extra high cycle.
- **Parity and 2 stop bits:** `PARITY_EN`=1, `STOP_BITS`=2, byte 0x07.
  - Even parity bit = 1; with `PARITY_ODD`=1, parity bit = 0.
  - Stop held 32 cycles; frame 192 cycles.
- **Empty FIFO:** `fifo_empty`=1 for 1000 cycles → `tx`=1, `busy`=0, `fifo_rd_en` never high.
- **Reset mid-frame:** assert `srst` during data bit 3 of 0x5A.
  - `tx`=1 and `busy`=0 before the next clock edge.
  - After release with 0x3C queued, a clean full-length frame of 0x3C follows.
- **Minimum divider:** `CLKS_PER_BIT`=2, byte 0x81 → each bit exactly 2 cycles; frame 20 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default divider and line idle level.
// The receiver imports the same package.
package uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam int   CLKS_PER_BIT_DEF = 868;  // 100 MHz / 115200
  localparam logic LINE_IDLE        = 1'b1;
endpackage

// File: rtl/uart_tx_if.sv
// FIFO read port plus serial line of the transmitter.
// The master side is the transmitter; the slave side is the FIFO and line environment.
interface uart_tx_if #(parameter int data_size = 8);
  logic [data_size-1:0] fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic                 tx;
  logic                 busy;

  modport master (input fifo_dout, fifo_empty, output fifo_rd_en, tx, busy);
  modport slave  (output fifo_dout, fifo_empty, input fifo_rd_en, tx, busy);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: emits a one-cycle tick on the last cycle of every bit.
// Clear restarts the period so a new frame is aligned to the load edge.
module uart_baud_gen import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic srst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int            CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a fall-through FIFO: start, LSB-first data, optional
// parity, 1 or 2 stop bits. The pop edge is also the edge that drives the start bit.
module uart_tx import uart_pkg::*; #(
  parameter int data_size    = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input logic       clk,
  input logic       srst,
  uart_tx_if.master bus
);
  localparam int            IW        = (data_size > 1) ? $clog2(data_size) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(data_size - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [data_size-1:0] shreg_q, shreg_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 tick, load;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .srst   (srst),
    .clr_i  (load),
    .en_i   (state_q != S_IDLE),
    .tick_o (tick)
  );

  // Reloading straight out of the last stop bit keeps back-to-back frames gapless.
  assign load = ((state_q == S_IDLE) ||
                 (state_q == S_STOP && tick && stop_q == LAST_STOP)) && !bus.fifo_empty;

  assign bus.fifo_rd_en = load && !srst;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    par_d   = par_q;
    case (state_q)
      S_START: if (tick) begin
        state_d = S_DATA;
        idx_d   = '0;
      end
      S_DATA: if (tick) begin
        shreg_d = shreg_q >> 1;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_PARITY: if (tick) begin
        state_d = S_STOP;
        stop_d  = 1'b0;
      end
      S_STOP: if (tick) begin
        if (stop_q == LAST_STOP) state_d = S_IDLE;
        else                     stop_d  = stop_q + 1'b1;
      end
      default: ;
    endcase
    if (load) begin
      state_d = S_START;
      shreg_d = bus.fifo_dout;
      idx_d   = '0;
      stop_d  = 1'b0;
      // Parity comes from the whole byte at load, before any shifting.
      par_d   = (^bus.fifo_dout) ^ 1'(PARITY_ODD);
    end
  end

  // Line and busy are registered from the next state so they change on the transition edge.
  always_comb begin
    tx_d   = LINE_IDLE;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end
endmodule
